read_from_keys: RTL

- User-input front end for the KPN demo; the counterpart of the 7-segment display writer.
- Debounces the digit and commit push buttons and assembles a 4-digit BCD operand from switch_value.
- Loads the operand into the entry/module register chosen by select_entry/select_module.
- After an entry-2 commit, pushes the operand pair into the target module's input FIFO, honouring the FIFO's full flag.

---
 rtl/read_from_keys_pkg.sv | 25 ++
 rtl/read_from_keys_key_debouncer.sv | 50 +++++
 rtl/read_from_keys.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/read_from_keys_pkg.sv
// Shared encodings for the KPN key front end: module codes, entry selects,
// controller states and BCD limits.
package read_from_keys_pkg;

  localparam logic [4:0] MODULE_ADDER_1      = 5'b00000;
  localparam logic [4:0] MODULE_SUBTRACTOR_1 = 5'b00001;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [2:0] DIGITS_MAX = 3'd4;

  typedef enum logic {
    ENTRY_1 = 1'b0,
    ENTRY_2 = 1'b1
  } entry_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_FIFO = 1'b1
  } state_t;

  function automatic logic module_valid(input logic [4:0] code);
    return (code == MODULE_ADDER_1) || (code == MODULE_SUBTRACTOR_1);
  endfunction

endpackage

// File: rtl/read_from_keys_key_debouncer.sv
// Synchronises one active-low push button, filters bounce, and emits a
// single-cycle pulse on each accepted released->pressed transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Levels are kept active-high so a cleared register means "released".
  logic                 sync_1;
  logic                 sync_2;
  logic                 sync_prev;
  logic                 accepted;
  logic [CNT_WIDTH-1:0] stable_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_prev   <= 1'b0;
      accepted    <= 1'b0;
      stable_cnt  <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= ~key_n;
      sync_2      <= sync_1;
      sync_prev   <= sync_2;
      press_pulse <= 1'b0;
      if (sync_2 != sync_prev) begin
        stable_cnt <= '0;
      end else if (sync_2 != accepted) begin
        // Only a level that differs from the accepted one needs qualifying.
        if (stable_cnt == CNT_LAST) begin
          accepted    <= sync_2;
          press_pulse <= sync_2;
          stable_cnt  <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/read_from_keys.sv
// Key front end: builds a 4-digit BCD operand from debounced key presses and
// loads it into the adder/subtractor operand registers, pushing complete pairs.
module read_from_keys
  import read_from_keys_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_digit,
  input  logic        key_commit,
  input  logic [3:0]  switch_value,
  input  logic        select_entry,
  input  logic [4:0]  select_module,
  input  logic        full_adder_1,
  input  logic        full_subtractor_1,
  output logic [15:0] data_1_adder_1,
  output logic [15:0] data_2_adder_1,
  output logic [15:0] data_1_subtractor_1,
  output logic [15:0] data_2_subtractor_1,
  output logic        write_adder_1,
  output logic        write_subtractor_1,
  output logic [15:0] edit_value,
  output logic        busy,
  output logic        error
);

  // FIFO push handshake: write_* is a registered one-cycle strobe raised only
  // when that FIFO's full flag was low on the previous edge; data_1/data_2 are
  // already stable and stay unchanged while the strobe is high.

  logic digit_pulse;
  logic commit_pulse;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_digit_deb (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_n      (key_digit),
    .press_pulse(digit_pulse)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_commit_deb (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_n      (key_commit),
    .press_pulse(commit_pulse)
  );

  state_t      state_q,   state_d;
  logic [15:0] edit_q,    edit_d;
  logic [2:0]  count_q,   count_d;
  logic [15:0] d1_add_q,  d1_add_d;
  logic [15:0] d2_add_q,  d2_add_d;
  logic [15:0] d1_sub_q,  d1_sub_d;
  logic [15:0] d2_sub_q,  d2_sub_d;
  logic        pend_sub_q, pend_sub_d;
  logic        wr_add_q,  wr_add_d;
  logic        wr_sub_q,  wr_sub_d;
  logic        error_q,   error_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      edit_q     <= '0;
      count_q    <= '0;
      d1_add_q   <= '0;
      d2_add_q   <= '0;
      d1_sub_q   <= '0;
      d2_sub_q   <= '0;
      pend_sub_q <= 1'b0;
      wr_add_q   <= 1'b0;
      wr_sub_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      count_q    <= count_d;
      d1_add_q   <= d1_add_d;
      d2_add_q   <= d2_add_d;
      d1_sub_q   <= d1_sub_d;
      d2_sub_q   <= d2_sub_d;
      pend_sub_q <= pend_sub_d;
      wr_add_q   <= wr_add_d;
      wr_sub_q   <= wr_sub_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    count_d    = count_q;
    d1_add_d   = d1_add_q;
    d2_add_d   = d2_add_q;
    d1_sub_d   = d1_sub_q;
    d2_sub_d   = d2_sub_q;
    pend_sub_d = pend_sub_q;
    wr_add_d   = 1'b0;
    wr_sub_d   = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Commit has priority; a digit pulse in the same cycle is dropped.
        if (commit_pulse) begin
          if (!module_valid(select_module)) begin
            error_d = 1'b1;
          end else begin
            if (select_module == MODULE_ADDER_1) begin
              if (select_entry == ENTRY_2) d2_add_d = edit_q;
              else                         d1_add_d = edit_q;
            end else begin
              if (select_entry == ENTRY_2) d2_sub_d = edit_q;
              else                         d1_sub_d = edit_q;
            end
            edit_d  = '0;
            count_d = '0;
            if (select_entry == ENTRY_2) begin
              pend_sub_d = (select_module == MODULE_SUBTRACTOR_1);
              state_d    = WAIT_FIFO;
            end
          end
        end else if (digit_pulse) begin
          if (switch_value > BCD_MAX) begin
            error_d = 1'b1;
          end else begin
            edit_d = {edit_q[11:0], switch_value};
            if (count_q != DIGITS_MAX) count_d = count_q + 3'd1;
          end
        end
      end

      WAIT_FIFO: begin
        // Key pulses are ignored here; only the latched module's full matters.
        if (pend_sub_q) begin
          if (!full_subtractor_1) begin
            wr_sub_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          if (!full_adder_1) begin
            wr_add_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_1_adder_1      = d1_add_q;
  assign data_2_adder_1      = d2_add_q;
  assign data_1_subtractor_1 = d1_sub_q;
  assign data_2_subtractor_1 = d2_sub_q;
  assign write_adder_1       = wr_add_q;
  assign write_subtractor_1  = wr_sub_q;
  assign edit_value          = edit_q;
  assign busy                = (state_q == WAIT_FIFO);
  assign error               = error_q;

endmodule
